regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file. Shares the file's single write port between two requesters: the ALU result path and the load-data (memory) path. Each requester uses a valid/ready handshake. Each cycle the arbiter grants at most one request by fixed priority plus an anti-starvation override, and drives the registered write strobe, address and data into the register file. Writes to x0 are consumed but never issued.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- STARVE_MAX, 3, consecutive lost cycles after which the ALU requester wins; range 1..15
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU write-back request
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU request accepted this cycle
- mem_valid  input  1  load write-back request
- mem_addr  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- mem_ready  output  1  load request accepted this cycle
- rf_write  output  1  register-file write strobe (registered)
- rf_write_add  output  ADDR_W  register-file write address (registered)
- rf_data  output  DATA_W  register-file write data (registered)
- starve_cnt  output  4  current count of consecutive ALU losses, for debug

## Operation
- Transfer: a request transfers on a rising edge where valid && ready. Requesters hold valid, addr and data stable until accepted.
- Ready is combinational from both valids and starve_cnt. Exactly one ready is high when any valid is high; neither is high when both valids are low.
- Default priority is mem over alu.
- Override: if alu_valid && starve_cnt == STARVE_MAX, alu wins.
- starve_cnt:
  - increments (saturating at STARVE_MAX) when alu_valid is high and alu loses.
  - clears when alu is accepted or alu_valid is low.
- Output register loads every cycle:
  - rf_write = accepted && (addr != 0)
  - rf_write_add and rf_data take the accepted values.
  - With no transfer, rf_write = 0 and addr/data hold their previous values.
- x0 request: accepted (ready high) and counts as a win, but rf_write stays 0.
- Both requesters naming the same register: the winner is written first and the loser on a later grant. Last grant wins in the register file.
- No internal request buffering. The output register is the only storage; back-pressure is carried only through ready.

## Timing
- Latency: accepted at edge N, so rf_write is high for the whole cycle following N. The register file commits on the falling edge inside that cycle.
- Throughput: one write per cycle, sustained.
- Reset (asynchronous): rf_write = 0, rf_write_add = 0, rf_data = 0, starve_cnt = 0.
- While rst is high, alu_ready = mem_ready = 0.
- Reset mid-operation: any write issued in the current cycle is dropped immediately because rf_write drops asynchronously. Requesters re-present their requests after reset releases.
- Both valid continuously: the grant sequence is mem ×STARVE_MAX, then alu, repeating.

## Configuration
- Macro WB_FWD_EN.
- Defined: adds the following ports.
  - Inputs: rd_add1, rd_add2 (ADDR_W), rf_rdata1, rf_rdata2 (DATA_W).
  - Outputs: fwd_data1, fwd_data2 (DATA_W).
- fwd_dataN = rf_data when rf_write && rd_addN == rf_write_add && rd_addN != 0; otherwise rf_rdataN.
- The forwarding path is combinational. It covers the first half-cycle, before the falling-edge commit.
- Undefined: these ports do not exist and no forwarding logic is built.

## Structure
- Shared package regfile_pkg:
  - DATA_W, ADDR_W
  - REG_X0 = 0
  - enum wb_src_t {WB_NONE, WB_ALU, WB_MEM}, used for the internal grant
- One sub-module: regfile_wb_fwd, a single forward mux. It is instantiated twice, only under WB_FWD_EN.

## Test plan
- Reset, then alu_valid with addr 5, data 0x6 → alu_ready = 1. The next cycle has rf_write = 1, rf_write_add = 5, rf_data = 6; the cycle after that has rf_write = 0.
- alu (addr 3, data 0x11) and mem (addr 3, data 0x22) both valid for one cycle each, with valid held → mem is granted first and alu next. Register 3 ends at 0x11.
- Both valid continuously for 12 cycles with STARVE_MAX = 3 → grants are M,M,M,A repeated 3×. starve_cnt peaks at 3.
- mem_valid with addr 0, data 0xFFFF → mem_ready = 1, rf_write remains 0. Register 0 remains 0.
- Assert rst asynchronously mid-cycle while rf_write = 1 → rf_write, rf_write_add, rf_data and starve_cnt go to 0 before the next edge, and both ready outputs read 0.
- With WB_FWD_EN: write addr 9, data 0x4 issued, rd_add1 = 9, rf_rdata1 = 0 → fwd_data1 = 4 during the write cycle. With rd_add2 = 0, fwd_data2 = rf_rdata2.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the register-file write-back path.
//   DATA_W   : register width
//   ADDR_W   : register index width (32 registers)
//   REG_X0   : index of the hardwired-zero register
//   wb_src_t : which requester owns the write port in a given cycle
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int REG_X0 = 0;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_t;

endpackage

// File: rtl/regfile_wb_fwd.sv
// regfile_wb_fwd
// Single read-port bypass mux. While a write is pending in the write-back
// output register (the register file commits it on the falling edge), a
// read of the same register gets the in-flight data instead of the stale
// array contents. Reads of x0 are never bypassed.
//
// Ports:
//   rf_write     in   write strobe from the write-back register
//   rf_write_add in   write address from the write-back register
//   rf_data      in   write data from the write-back register
//   rd_add       in   read address of this port
//   rf_rdata     in   raw read data from the register array
//   fwd_data     out  bypassed read data (combinational)
module regfile_wb_fwd
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              rf_write,
    input  logic [ADDR_W-1:0] rf_write_add,
    input  logic [DATA_W-1:0] rf_data,
    input  logic [ADDR_W-1:0] rd_add,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [DATA_W-1:0] fwd_data
);

    logic hit;

    assign hit = rf_write
              && (rd_add == rf_write_add)
              && (rd_add != ADDR_W'(REG_X0));

    assign fwd_data = hit ? rf_data : rf_rdata;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU result path
// and the load-data path. Fixed priority is mem over alu; once the ALU has
// lost STARVE_MAX cycles in a row while requesting, it is granted instead.
// The granted request is captured into a registered write strobe /
// address / data that drive the register file one cycle after acceptance.
// Requests to x0 are accepted but never produce a write strobe.
//
// Optional feature macro: WB_FWD_EN
//   When defined, two combinational read-bypass ports are added so that a
//   read of the register being written in the current cycle sees the new
//   value before the register file commits it on the falling edge.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   alu_valid     in   ALU write-back request
//   alu_addr      in   ALU destination register
//   alu_data      in   ALU result
//   alu_ready     out  ALU request accepted this cycle (combinational)
//   mem_valid     in   load write-back request
//   mem_addr      in   load destination register
//   mem_data      in   load data
//   mem_ready     out  load request accepted this cycle (combinational)
//   rf_write      out  register-file write strobe (registered)
//   rf_write_add  out  register-file write address (registered)
//   rf_data       out  register-file write data (registered)
//   rd_add1/2     in   read addresses            (WB_FWD_EN only)
//   rf_rdata1/2   in   raw register-file reads   (WB_FWD_EN only)
//   fwd_data1/2   out  bypassed read data        (WB_FWD_EN only)
//   starve_cnt    out  consecutive ALU losses, debug
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,

    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,

    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_write_add,
    output logic [DATA_W-1:0] rf_data,

`ifdef WB_FWD_EN
    input  logic [ADDR_W-1:0] rd_add1,
    input  logic [ADDR_W-1:0] rd_add2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif

    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    wb_src_t           grant;
    logic              starve_hit;
    logic              accepted;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [3:0]        starve_nxt;

    assign starve_hit = alu_valid && (starve_cnt == STARVE_LIM);

    // Grant: starvation override first, then mem over alu.
    always_comb begin
        grant = WB_NONE;
        if (starve_hit) begin
            grant = WB_ALU;
        end else if (mem_valid) begin
            grant = WB_MEM;
        end else if (alu_valid) begin
            grant = WB_ALU;
        end
    end

    // Ready is masked during reset so nothing is consumed while the
    // output register is being held clear.
    assign alu_ready = !rst && (grant == WB_ALU);
    assign mem_ready = !rst && (grant == WB_MEM);
    assign accepted  = (grant != WB_NONE);

    always_comb begin
        acc_addr = rf_write_add;
        acc_data = rf_data;
        case (grant)
            WB_ALU: begin
                acc_addr = alu_addr;
                acc_data = alu_data;
            end
            WB_MEM: begin
                acc_addr = mem_addr;
                acc_data = mem_data;
            end
            default: begin
                acc_addr = rf_write_add;
                acc_data = rf_data;
            end
        endcase
    end

    // Count only cycles in which the ALU asked and lost; any ALU win or an
    // idle ALU cycle restarts the count.
    always_comb begin
        starve_nxt = 4'd0;
        if (alu_valid && (grant != WB_ALU)) begin
            if (starve_cnt >= STARVE_LIM) begin
                starve_nxt = STARVE_LIM;
            end else begin
                starve_nxt = starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_write     <= 1'b0;
            rf_write_add <= '0;
            rf_data      <= '0;
            starve_cnt   <= 4'd0;
        end else begin
            starve_cnt <= starve_nxt;
            // x0 requests are consumed here: address/data are captured but
            // the strobe stays low.
            rf_write   <= accepted && (acc_addr != ADDR_W'(REG_X0));
            if (accepted) begin
                rf_write_add <= acc_addr;
                rf_data      <= acc_data;
            end
        end
    end

`ifdef WB_FWD_EN
    regfile_wb_fwd #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd1 (
        .rf_write     (rf_write),
        .rf_write_add (rf_write_add),
        .rf_data      (rf_data),
        .rd_add       (rd_add1),
        .rf_rdata     (rf_rdata1),
        .fwd_data     (fwd_data1)
    );

    regfile_wb_fwd #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fwd2 (
        .rf_write     (rf_write),
        .rf_write_add (rf_write_add),
        .rf_data      (rf_data),
        .rd_add       (rd_add2),
        .rf_rdata     (rf_rdata2),
        .fwd_data     (fwd_data2)
    );
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Directed bench for regfile_wb_arbiter. A small register-array model
// commits rf_write on each falling edge, standing in for the real file.
// Forwarding checks are built only when WB_FWD_EN is defined.
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          rf_write;
    logic [AW-1:0] rf_write_add;
    logic [DW-1:0] rf_data;
    logic [3:0]    starve_cnt;
`ifdef WB_FWD_EN
    logic [AW-1:0] rd_add1;
    logic [AW-1:0] rd_add2;
    logic [DW-1:0] rf_rdata1;
    logic [DW-1:0] rf_rdata2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
`endif

    int total;
    int bad;

    logic [DW-1:0] rf_model [32];

    regfile_wb_arbiter #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .STARVE_MAX (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .mem_valid    (mem_valid),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .rf_write     (rf_write),
        .rf_write_add (rf_write_add),
        .rf_data      (rf_data),
`ifdef WB_FWD_EN
        .rd_add1      (rd_add1),
        .rd_add2      (rd_add2),
        .rf_rdata1    (rf_rdata1),
        .rf_rdata2    (rf_rdata2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
`endif
        .starve_cnt   (starve_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register array: commits on the falling edge, x0 included, so any
    // strobe issued for x0 shows up as a corrupted register 0.
    initial begin
        for (int i = 0; i < 32; i++) rf_model[i] = '0;
        forever begin
            @(negedge clk);
            if (rf_write === 1'b1) rf_model[rf_write_add] = rf_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h1;
        mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h2;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL reset_rf_write got=%0b exp=0", rf_write); end
        total++; if (rf_write_add !== 5'd0) begin bad++; $display("FAIL reset_rf_add got=%0d exp=0", rf_write_add); end
        total++; if (rf_data !== 32'd0) begin bad++; $display("FAIL reset_rf_data got=%0h exp=0", rf_data); end
        total++; if (starve_cnt !== 4'd0) begin bad++; $display("FAIL reset_starve got=%0d exp=0", starve_cnt); end
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL reset_alu_ready got=%0b exp=0", alu_ready); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL reset_mem_ready got=%0b exp=0", mem_ready); end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL idle_rf_write got=%0b exp=0", rf_write); end
    endtask

    task automatic test_single_alu();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h6;
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL single_alu_ready got=%0b exp=1", alu_ready); end
        total++; if (mem_ready !== 1'b0) begin bad++; $display("FAIL single_mem_ready got=%0b exp=0", mem_ready); end
        step();
        alu_valid = 1'b0;
        total++; if (rf_write !== 1'b1) begin bad++; $display("FAIL single_rf_write got=%0b exp=1", rf_write); end
        total++; if (rf_write_add !== 5'd5) begin bad++; $display("FAIL single_rf_add got=%0d exp=5", rf_write_add); end
        total++; if (rf_data !== 32'h6) begin bad++; $display("FAIL single_rf_data got=%0h exp=6", rf_data); end
        step();
        total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL single_after_write got=%0b exp=0", rf_write); end
        total++; if (rf_write_add !== 5'd5) begin bad++; $display("FAIL single_hold_add got=%0d exp=5", rf_write_add); end
        total++; if (rf_data !== 32'h6) begin bad++; $display("FAIL single_hold_data got=%0h exp=6", rf_data); end
        total++; if (rf_model[5] !== 32'h6) begin bad++; $display("FAIL single_rf_commit got=%0h exp=6", rf_model[5]); end
    endtask

    task automatic test_same_reg();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h22;
        #1;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL same_mem_first got=%0b exp=1", mem_ready); end
        total++; if (alu_ready !== 1'b0) begin bad++; $display("FAIL same_alu_waits got=%0b exp=0", alu_ready); end
        step();
        mem_valid = 1'b0;
        total++; if (rf_data !== 32'h22) begin bad++; $display("FAIL same_first_data got=%0h exp=22", rf_data); end
        total++; if (starve_cnt !== 4'd1) begin bad++; $display("FAIL same_starve got=%0d exp=1", starve_cnt); end
        #1;
        total++; if (alu_ready !== 1'b1) begin bad++; $display("FAIL same_alu_next got=%0b exp=1", alu_ready); end
        step();
        alu_valid = 1'b0;
        total++; if (rf_write !== 1'b1 || rf_write_add !== 5'd3 || rf_data !== 32'h11) begin
            bad++; $display("FAIL same_second_write got=%0b/%0d/%0h exp=1/3/11", rf_write, rf_write_add, rf_data);
        end
        total++; if (starve_cnt !== 4'd0) begin bad++; $display("FAIL same_starve_clear got=%0d exp=0", starve_cnt); end
        @(negedge clk);
        #1;
        total++; if (rf_model[3] !== 32'h11) begin bad++; $display("FAIL same_reg3_final got=%0h exp=11", rf_model[3]); end
    endtask

    task automatic test_starvation();
        int peak;
        peak = 0;
        alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'hA0A0;
        mem_valid = 1'b1; mem_addr = 5'd2; mem_data = 32'hB0B0;
        for (int i = 0; i < 12; i++) begin
            #1;
            total++; if (alu_ready !== ((i % 4) == 3)) begin bad++; $display("FAIL starve_alu_ready cyc=%0d got=%0b exp=%0b", i, alu_ready, (i % 4) == 3); end
            total++; if (mem_ready !== ((i % 4) != 3)) begin bad++; $display("FAIL starve_mem_ready cyc=%0d got=%0b exp=%0b", i, mem_ready, (i % 4) != 3); end
            total++; if (starve_cnt !== 4'(i % 4)) begin bad++; $display("FAIL starve_cnt cyc=%0d got=%0d exp=%0d", i, starve_cnt, i % 4); end
            if (int'(starve_cnt) > peak) peak = int'(starve_cnt);
            step();
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        total++; if (peak != 3) begin bad++; $display("FAIL starve_peak got=%0d exp=3", peak); end
        total++; if (rf_write_add !== 5'd1 || rf_data !== 32'hA0A0) begin
            bad++; $display("FAIL starve_last_grant got=%0d/%0h exp=1/a0a0", rf_write_add, rf_data);
        end
        step();
    endtask

    task automatic test_x0();
        mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFF;
        #1;
        total++; if (mem_ready !== 1'b1) begin bad++; $display("FAIL x0_mem_ready got=%0b exp=1", mem_ready); end
        step();
        mem_valid = 1'b0;
        total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL x0_rf_write got=%0b exp=0", rf_write); end
        total++; if (rf_write_add !== 5'd0 || rf_data !== 32'hFFFF) begin
            bad++; $display("FAIL x0_captured got=%0d/%0h exp=0/ffff", rf_write_add, rf_data);
        end
        @(negedge clk);
        #1;
        total++; if (rf_model[0] !== 32'd0) begin bad++; $display("FAIL x0_reg0 got=%0h exp=0", rf_model[0]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1;
            alu_addr  = 5'(10 + i);
            alu_data  = 32'h100 + 32'(i);
            step();
            total++; if (rf_write !== 1'b1 || rf_write_add !== 5'(10 + i) || rf_data !== 32'h100 + 32'(i)) begin
                bad++; $display("FAIL b2b_write i=%0d got=%0b/%0d/%0h exp=1/%0d/%0h", i, rf_write, rf_write_add, rf_data, 10 + i, 32'h100 + 32'(i));
            end
        end
        alu_valid = 1'b0;
        step();
        total++; if (rf_model[11] !== 32'h101) begin bad++; $display("FAIL b2b_reg11 got=%0h exp=101", rf_model[11]); end
    endtask

    task automatic test_async_reset();
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h55;
        mem_valid = 1'b1; mem_addr = 5'd8; mem_data = 32'h66;
        step();
        total++; if (rf_write !== 1'b1 || starve_cnt !== 4'd1) begin
            bad++; $display("FAIL arst_pre got=%0b/%0d exp=1/1", rf_write, starve_cnt);
        end
        #2 rst = 1'b1;
        #1;
        total++; if (rf_write !== 1'b0) begin bad++; $display("FAIL arst_rf_write got=%0b exp=0", rf_write); end
        total++; if (rf_write_add !== 5'd0) begin bad++; $display("FAIL arst_rf_add got=%0d exp=0", rf_write_add); end
        total++; if (rf_data !== 32'd0) begin bad++; $display("FAIL arst_rf_data got=%0h exp=0", rf_data); end
        total++; if (starve_cnt !== 4'd0) begin bad++; $display("FAIL arst_starve got=%0d exp=0", starve_cnt); end
        total++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            bad++; $display("FAIL arst_ready got=%0b/%0b exp=0/0", alu_ready, mem_ready);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        #1;
        total++; if (rf_model[8] !== 32'd0) begin bad++; $display("FAIL arst_write_dropped got=%0h exp=0", rf_model[8]); end
        rst = 1'b0;
        step();
    endtask

`ifdef WB_FWD_EN
    task automatic test_forward();
        rd_add1 = 5'd9; rf_rdata1 = 32'd0;
        rd_add2 = 5'd0; rf_rdata2 = 32'h77;
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h4;
        step();
        alu_valid = 1'b0;
        total++; if (fwd_data1 !== 32'h4) begin bad++; $display("FAIL fwd1_hit got=%0h exp=4", fwd_data1); end
        total++; if (fwd_data2 !== 32'h77) begin bad++; $display("FAIL fwd2_x0 got=%0h exp=77", fwd_data2); end
        rf_rdata1 = 32'h99;
        step();
        total++; if (fwd_data1 !== 32'h99) begin bad++; $display("FAIL fwd1_idle got=%0h exp=99", fwd_data1); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
`ifdef WB_FWD_EN
        rd_add1 = '0; rd_add2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
`endif
        test_reset();
        test_single_alu();
        test_same_reg();
        test_starvation();
        test_x0();
        test_back_to_back();
        test_async_reset();
`ifdef WB_FWD_EN
        test_forward();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
